// File: rtl/ds1302_target_if.sv
// 3-wire serial bus between a DS1302-style master and the target.
//   i_ce      chip enable, high = frame active (master -> target)
//   i_sclk    serial clock, idles low (master -> target)
//   i_sda     IO line as seen at the pad (resolved pad value, into target)
//   o_sda     IO drive value from target
//   o_sda_oe  1 = target drives the pad with o_sda
interface ds1302_target_if;
    logic i_ce;
    logic i_sclk;
    logic i_sda;
    logic o_sda;
    logic o_sda_oe;

    modport master (
        output i_ce,
        output i_sclk,
        output i_sda,
        input  o_sda,
        input  o_sda_oe
    );

    modport slave (
        input  i_ce,
        input  i_sclk,
        input  i_sda,
        output o_sda,
        output o_sda_oe
    );
endinterface

// File: rtl/ds1302_target.sv
// DS1302-style 3-wire serial target with a clock bank (RC=0) and a RAM bank (RC=1), 32x8 each.
// CE/SCLK/IO are oversampled on clk (clk must be >= 8x SCLK). A command byte is shifted in
// LSB-first (RW, A4..A0, RC, marker), followed by one data byte MSB-first, written or read.
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   sio               serial bus (slave modport)
//   o_wr_strobe       1-clk pulse when a serial write is committed; o_wr_bank/addr/data describe it
//   o_cmd_err         1-clk pulse when a command byte with marker bit 0 is rejected
//   i_lcl_bank/addr   local read select; o_lcl_data is the registered bank byte, 1 clk latency
module ds1302_target #(
    parameter int unsigned SYNC_STAGES = 2,      // flops per synchronizer, at least 2
    parameter bit          WP_EN       = 1'b1,   // clock-bank write protect enable
    parameter logic [4:0]  WP_ADDR     = 5'd7    // clock-bank address holding WP in bit 7
) (
    input  logic             clk,
    input  logic             reset,
    ds1302_target_if.slave   sio,
    output logic             o_wr_strobe,
    output logic             o_wr_bank,
    output logic [4:0]       o_wr_addr,
    output logic [7:0]       o_wr_data,
    output logic             o_cmd_err,
    input  logic             i_lcl_bank,
    input  logic [4:0]       i_lcl_addr,
    output logic [7:0]       o_lcl_data
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWrData,
        StWrCommit,
        StRdData,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] ce_sync_q, sclk_sync_q, sda_sync_q;
    logic                   ce_last_q, sclk_last_q;
    logic                   ce_s, sclk_s, sda_s;
    logic                   ce_fall, sclk_rise, sclk_fall;

    logic [3:0] cnt_q, cnt_d;
    logic [6:0] cmd_q, cmd_d;       // bit i = i-th wire bit; marker is never stored
    logic [7:0] shift_q, shift_d;
    logic       oe_q, oe_d;
    logic       cmd_err_q, cmd_err_d;
    logic       commit;

    logic [7:0] bank_q [2][32];
    logic       wr_strobe_q, wr_bank_q;
    logic [4:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [7:0] lcl_data_q;

    logic       cmd_rw, cmd_bank;
    logic [4:0] cmd_addr;
    logic       wp_block;

    // Synchronizers plus one extra flop per control line for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_sync_q   <= '0;
            sclk_sync_q <= '0;
            sda_sync_q  <= '0;
            ce_last_q   <= 1'b0;
            sclk_last_q <= 1'b0;
        end else begin
            ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], sio.i_ce};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sio.i_sclk};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sio.i_sda};
            ce_last_q   <= ce_s;
            sclk_last_q <= sclk_s;
        end
    end

    assign ce_s      = ce_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign ce_fall   = ce_last_q & ~ce_s;
    assign sclk_rise = sclk_s & ~sclk_last_q;
    assign sclk_fall = ~sclk_s & sclk_last_q;

    // Address arrives MSB first, so A4 sits at wire bit 1
    assign cmd_rw   = cmd_q[0];
    assign cmd_bank = cmd_q[6];
    assign cmd_addr = {cmd_q[1], cmd_q[2], cmd_q[3], cmd_q[4], cmd_q[5]};

    // The WP address itself stays writable so protection can be lifted
    assign wp_block = WP_EN && bank_q[0][WP_ADDR][7] && !cmd_bank && (cmd_addr != WP_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        shift_d   = shift_q;
        oe_d      = oe_q;
        cmd_err_d = 1'b0;
        commit    = 1'b0;

        if (ce_fall) begin
            // Abort from any state; a partial write is simply dropped
            state_d = StIdle;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    oe_d  = 1'b0;
                    if (ce_s) begin
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            if (!sda_s) begin
                                state_d   = StErr;
                                cmd_err_d = 1'b1;
                            end else if (cmd_q[0]) begin
                                state_d = StRdData;
                            end else begin
                                state_d = StWrData;
                            end
                        end else begin
                            cmd_d[cnt_q[2:0]] = sda_s;
                            cnt_d             = cnt_q + 4'd1;
                        end
                    end
                end
                StWrData: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (cnt_q == 4'd7) begin
                            cnt_d   = '0;
                            state_d = StWrCommit;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                StWrCommit: begin
                    commit  = !wp_block;
                    state_d = StDone;
                end
                StRdData: begin
                    // cnt_q counts data bits already presented on the line
                    if (sclk_fall) begin
                        if (cnt_q == 4'd0) begin
                            shift_d = bank_q[cmd_bank][cmd_addr];
                            oe_d    = 1'b1;
                            cnt_d   = 4'd1;
                        end else if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = StDone;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                StDone, StErr: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            cmd_q       <= '0;
            shift_q     <= '0;
            oe_q        <= 1'b0;
            cmd_err_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            lcl_data_q  <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < 32; a++) begin
                    bank_q[b][a] <= '0;
                end
            end
        end else begin
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            oe_q        <= oe_d;
            cmd_err_q   <= cmd_err_d;
            wr_strobe_q <= commit;
            if (commit) begin
                bank_q[cmd_bank][cmd_addr] <= shift_q;
                wr_bank_q                  <= cmd_bank;
                wr_addr_q                  <= cmd_addr;
                wr_data_q                  <= shift_q;
            end
            // No bypass: a commit on this edge shows up one clk later
            lcl_data_q <= bank_q[i_lcl_bank][i_lcl_addr];
        end
    end

    assign sio.o_sda    = oe_q & shift_q[7];
    assign sio.o_sda_oe = oe_q;
    assign o_wr_strobe  = wr_strobe_q;
    assign o_wr_bank    = wr_bank_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_cmd_err    = cmd_err_q;
    assign o_lcl_data   = lcl_data_q;

endmodule
